// File: rtl/read_port_burst.sv
// rtl/read_port_burst.sv - register-file read port with single and auto-incrementing burst reads
// One beat per cycle from the accept edge on; out-of-range beats return zero with rd_err_o.
module read_port_burst #(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       N_REG     = 7,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       LEN_W     = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      rd_req_i,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  input  logic [LEN_W-1:0]          rd_len_i,
  input  logic [N_REG*DATA_W-1:0]   reg_in_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      rd_valid_o,
  output logic                      rd_last_o,
  output logic                      rd_err_o,
  output logic                      rd_busy_o
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              rd_err_q;

  logic              accept_d;
  logic              beat_load_d;
  logic [ADDR_W-1:0] beat_addr_d;
  logic [ADDR_W-1:0] beat_idx_d;
  logic              in_range_d;
  logic [LEN_W-1:0]  accept_rem_d;
  logic [DATA_W-1:0] beat_data_d;

  always_comb begin
    accept_d     = (state_q == IDLE) && rd_req_i;
    beat_load_d  = accept_d || (state_q == BURST);
    beat_addr_d  = (state_q == BURST) ? cur_addr_q : rd_addr_i;
    // Subtraction wraps modulo 2**ADDR_W, so addresses below BASE_ADDR land far out of range.
    beat_idx_d   = beat_addr_d - BASE_ADDR;
    in_range_d   = {1'b0, beat_idx_d} < (ADDR_W+1)'(N_REG);
    accept_rem_d = (rd_len_i == '0) ? '0 : rd_len_i - LEN_W'(1);
    beat_data_d  = '0;
    for (int unsigned k = 0; k < N_REG; k++) begin
      if (beat_idx_d == ADDR_W'(k)) begin
        beat_data_d = reg_in_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= beat_load_d;
      if (beat_load_d) begin
        rd_data_q <= in_range_d ? beat_data_d : '0;
        rd_err_q  <= !in_range_d;
      end else begin
        rd_err_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rd_req_i) begin
            cur_addr_q <= rd_addr_i + ADDR_W'(1);
            rem_q      <= accept_rem_d;
            rd_last_q  <= (accept_rem_d == '0);
            state_q    <= (accept_rem_d == '0) ? IDLE : BURST;
          end else begin
            rd_last_q  <= 1'b0;
          end
        end
        BURST: begin
          cur_addr_q <= cur_addr_q + ADDR_W'(1);
          rem_q      <= rem_q - LEN_W'(1);
          rd_last_q  <= (rem_q == LEN_W'(1));
          if (rem_q == LEN_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign rd_err_o   = rd_err_q;
  assign rd_busy_o  = (state_q == BURST);

endmodule

// File: tb/tb_read_port_burst.sv
// tb/tb_read_port_burst.sv - scoreboard bench for read_port_burst
// Two instances: default parameters, and BASE_ADDR=FE with N_REG=4 for the wrap case.
module tb_read_port_burst;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  logic         req0 = 1'b0;
  logic [7:0]   addr0 = '0;
  logic [2:0]   len0 = '0;
  logic [447:0] regin0;
  logic [63:0]  data0;
  logic         valid0, last0, err0, busy0;
  logic [63:0]  rv [7] = '{64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                           64'h0000_0000_DEAD_BEEF, 64'h3333_3333_3333_3333,
                           64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                           64'hCCCC_CCCC_CCCC_CCCC};

  logic         req1 = 1'b0;
  logic [7:0]   addr1 = '0;
  logic [2:0]   len1 = '0;
  logic [63:0]  regin1 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
  logic [15:0]  data1;
  logic         valid1, last1, err1, busy1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t a0, e0, a1, e1;

  always_comb begin
    regin0 = '0;
    for (int k = 0; k < 7; k++) regin0[k*64 +: 64] = rv[k];
  end

  read_port_burst u0 (
    .clk_i(clk), .reset_i(rst), .rd_req_i(req0), .rd_addr_i(addr0), .rd_len_i(len0),
    .reg_in_i(regin0), .rd_data_o(data0), .rd_valid_o(valid0), .rd_last_o(last0),
    .rd_err_o(err0), .rd_busy_o(busy0)
  );

  read_port_burst #(.DATA_W(16), .N_REG(4), .ADDR_W(8), .BASE_ADDR(8'hFE), .LEN_W(3)) u1 (
    .clk_i(clk), .reset_i(rst), .rd_req_i(req1), .rd_addr_i(addr1), .rd_len_i(len1),
    .reg_in_i(regin1), .rd_data_o(data1), .rd_valid_o(valid1), .rd_last_o(last1),
    .rd_err_o(err1), .rd_busy_o(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (valid0) begin
      a0 = {data0, last0, err0, 32'(cyc)};
      if (q0.size() == 0) begin
        checks++;
        $display("FAIL u0 unexpected beat actual=%h expected=none", a0);
      end else begin
        e0 = q0.pop_front();
        chk("u0 beat {data,last,err,cyc}", 128'(a0), 128'(e0));
      end
    end
    if (valid1) begin
      a1 = {48'h0, data1, last1, err1, 32'(cyc)};
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL u1 unexpected beat actual=%h expected=none", a1);
      end else begin
        e1 = q1.pop_front();
        chk("u1 beat {data,last,err,cyc}", 128'(a1), 128'(e1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input logic [63:0] d, input logic l, input logic e, input int c);
    q0.push_back({d, l, e, 32'(c)});
  endtask

  task automatic push1(input logic [63:0] d, input logic l, input logic e, input int c);
    q1.push_back({d, l, e, 32'(c)});
  endtask

  task automatic go0(input logic [7:0] a, input logic [2:0] l);
    addr0 = a; len0 = l; req0 = 1'b1;
    tick(1);
    req0 = 1'b0;
  endtask

  task automatic go1(input logic [7:0] a, input logic [2:0] l);
    addr1 = a; len1 = l; req1 = 1'b1;
    tick(1);
    req1 = 1'b0;
  endtask

  int c;

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset u0 outputs", 128'({data0, valid0, last0, err0, busy0}), 128'(0));
    chk("reset u1 outputs", 128'({data1, valid1, last1, err1, busy1}), 128'(0));
    tick(1);
    rst = 1'b0;
    tick(1);

    // single read
    c = cyc;
    push0(64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0, c + 1);
    go0(8'd2, 3'd1);
    chk("single busy", 128'(busy0), 128'(0));
    tick(1);
    chk("idle holds data, valid low", 128'({data0, valid0}), 128'({64'h0000_0000_DEAD_BEEF, 1'b0}));
    tick(1);

    // burst of 3, reg6 changed mid-burst to show per-beat sampling
    c = cyc;
    push0(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, c + 1);
    push0(64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b0, c + 2);
    push0(64'hC0DE_C0DE_C0DE_C0DE, 1'b1, 1'b0, c + 3);
    go0(8'd4, 3'd3);
    chk("burst busy beat0", 128'(busy0), 128'(1));
    rv[6] = 64'hC0DE_C0DE_C0DE_C0DE;
    tick(1);
    chk("burst busy beat1", 128'(busy0), 128'(1));
    tick(1);
    chk("burst busy beat2", 128'(busy0), 128'(0));
    tick(1);
    chk("burst valid after last", 128'(valid0), 128'(0));
    tick(1);

    // range: reg6 then two out-of-range beats
    c = cyc;
    push0(64'hC0DE_C0DE_C0DE_C0DE, 1'b0, 1'b0, c + 1);
    push0(64'h0, 1'b0, 1'b1, c + 2);
    push0(64'h0, 1'b1, 1'b1, c + 3);
    go0(8'd6, 3'd3);
    tick(4);

    // address wrap FE, FF, 00, 01 with BASE_ADDR=0
    c = cyc;
    push0(64'h0, 1'b0, 1'b1, c + 1);
    push0(64'h0, 1'b0, 1'b1, c + 2);
    push0(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, c + 3);
    push0(64'h1111_2222_3333_4444, 1'b1, 1'b0, c + 4);
    go0(8'hFE, 3'd4);
    tick(5);

    // len=0 behaves as a single beat
    c = cyc;
    push0(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, c + 1);
    go0(8'd0, 3'd0);
    tick(2);

    // maximum burst length
    c = cyc;
    push0(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, c + 1);
    push0(64'h1111_2222_3333_4444, 1'b0, 1'b0, c + 2);
    push0(64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, c + 3);
    push0(64'h3333_3333_3333_3333, 1'b0, 1'b0, c + 4);
    push0(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, c + 5);
    push0(64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b0, c + 6);
    push0(64'hC0DE_C0DE_C0DE_C0DE, 1'b1, 1'b0, c + 7);
    go0(8'd0, 3'd7);
    tick(8);

    // request held through busy, new request in last-beat cycle follows with no gap
    c = cyc;
    push0(64'h1111_2222_3333_4444, 1'b0, 1'b0, c + 1);
    push0(64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, c + 2);
    push0(64'h3333_3333_3333_3333, 1'b1, 1'b0, c + 3);
    push0(64'hBBBB_BBBB_BBBB_BBBB, 1'b1, 1'b0, c + 4);
    addr0 = 8'd1; len0 = 3'd3; req0 = 1'b1;
    tick(3);
    addr0 = 8'd5; len0 = 3'd1;
    tick(1);
    req0 = 1'b0;
    tick(2);

    // reset after beat 1 of a len=5 burst
    c = cyc;
    push0(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, c + 1);
    push0(64'h1111_2222_3333_4444, 1'b0, 1'b0, c + 2);
    go0(8'd0, 3'd5);
    tick(1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid-burst reset outputs", 128'({data0, valid0, last0, err0, busy0}), 128'(0));
    tick(2);
    rst = 1'b0;
    tick(2);
    c = cyc;
    push0(64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0, c + 1);
    go0(8'd2, 3'd1);
    tick(2);

    // BASE_ADDR=FE instance: wrapping in-range burst, below-base and above-range beats
    c = cyc;
    push1(64'h1000, 1'b0, 1'b0, c + 1);
    push1(64'h1001, 1'b0, 1'b0, c + 2);
    push1(64'h1002, 1'b0, 1'b0, c + 3);
    push1(64'h1003, 1'b1, 1'b0, c + 4);
    go1(8'hFE, 3'd4);
    tick(5);
    c = cyc;
    push1(64'h0, 1'b1, 1'b1, c + 1);
    go1(8'hFD, 3'd1);
    tick(2);
    c = cyc;
    push1(64'h0, 1'b0, 1'b1, c + 1);
    push1(64'h0, 1'b1, 1'b1, c + 2);
    go1(8'h02, 3'd2);
    tick(3);

    chk("u0 scoreboard drained", 128'(q0.size()), 128'(0));
    chk("u1 scoreboard drained", 128'(q1.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
